// File: rtl/md_pkg.sv
// Shared encodings and helpers for the execute-stage multiply/divide unit.
package md_pkg;

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULHU = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_REMU  = 3'd3;
    localparam logic [2:0] OP_DIV   = 3'd4;
    localparam logic [2:0] OP_REM   = 3'd5;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    function automatic logic is_signed(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIVU) || (op == OP_REMU) ||
               (op == OP_DIV)  || (op == OP_REM);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand resolver: x0, then youngest matching forwarding source, else regfile.
module fwd_select #(
    parameter int NFWD  = 4,
    parameter int WIDTH = 32,
    parameter int RBITS = 5
) (
    input  logic [RBITS-1:0]      spec,
    input  logic [WIDTH-1:0]      reg_val,
    input  logic [NFWD*RBITS-1:0] fwd_tgt,
    input  logic [NFWD*WIDTH-1:0] fwd_data,
    input  logic [NFWD-1:0]       fwd_valid,
    output logic [WIDTH-1:0]      operand
);

    always_comb begin
        operand = reg_val;
        // Walk oldest to youngest so the lowest index wins.
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_tgt[i*RBITS +: RBITS] == spec)) begin
                operand = fwd_data[i*WIDTH +: WIDTH];
            end
        end
        if (spec == '0) begin
            operand = '0;
        end
    end

endmodule

// File: rtl/execute_muldiv.sv
// Iterative radix-2 multiply / restoring divide beside the execute ALU.
module execute_muldiv #(
    parameter int WIDTH = 32,
    parameter int NFWD  = 4,
    parameter int RBITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  kill,
    input  logic                  bubble_in,
    input  logic                  md_valid,
    input  logic [2:0]            md_op,
    input  logic [RBITS-1:0]      s_1,
    input  logic [RBITS-1:0]      s_2,
    input  logic [RBITS-1:0]      tgt,
    input  logic [WIDTH-1:0]      reg_out_1,
    input  logic [WIDTH-1:0]      reg_out_2,
    input  logic [NFWD*RBITS-1:0] fwd_tgt,
    input  logic [NFWD*WIDTH-1:0] fwd_data,
    input  logic [NFWD-1:0]       fwd_valid,
    output logic [WIDTH-1:0]      result,
    output logic [RBITS-1:0]      tgt_out,
    output logic                  bubble_out,
    output logic                  stall,
    output logic                  busy
);
    import md_pkg::*;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] op1, op2, mag1, mag2;
    logic             sa, sb, go;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [RBITS-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] a_q, a_d, hi_q, hi_d, lo_q, lo_d;
    logic             dz_q, dz_d, nq_q, nq_d, nr_q, nr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [RBITS-1:0] tgt_out_q, tgt_out_d;
    logic             bubble_q, bubble_d;

    logic [WIDTH:0]   sum, rem_sh;
    logic             ge;
    logic [WIDTH-1:0] hi_n, lo_n, final_res;

    fwd_select #(.NFWD(NFWD), .WIDTH(WIDTH), .RBITS(RBITS)) u_fwd_1 (
        .spec(s_1), .reg_val(reg_out_1), .fwd_tgt(fwd_tgt),
        .fwd_data(fwd_data), .fwd_valid(fwd_valid), .operand(op1)
    );

    fwd_select #(.NFWD(NFWD), .WIDTH(WIDTH), .RBITS(RBITS)) u_fwd_2 (
        .spec(s_2), .reg_val(reg_out_2), .fwd_tgt(fwd_tgt),
        .fwd_data(fwd_data), .fwd_valid(fwd_valid), .operand(op2)
    );

    assign sa   = is_signed(md_op) & op1[WIDTH-1];
    assign sb   = is_signed(md_op) & op2[WIDTH-1];
    assign mag1 = sa ? -op1 : op1;
    assign mag2 = sb ? -op2 : op2;

    assign go    = md_valid & ~bubble_in & ~kill & (state_q == S_IDLE);
    assign stall = md_valid & ~bubble_in & ~kill &
                   ((state_q == S_IDLE) | (cnt_q != '0));

    // One iteration step; the final step feeds the result mux directly.
    always_comb begin
        sum    = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : {WIDTH{1'b0}})};
        rem_sh = {hi_q, lo_q[WIDTH-1]};
        ge     = rem_sh >= {1'b0, a_q};
        if (is_div(op_q)) begin
            hi_n = ge ? (rem_sh[WIDTH-1:0] - a_q) : rem_sh[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], ge};
        end else begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        case (op_q)
            OP_MULHU: final_res = hi_n;
            OP_DIVU:  final_res = dz_q ? '1 : lo_n;
            OP_REMU:  final_res = hi_n;
            OP_DIV:   final_res = dz_q ? '1 : (nq_q ? -lo_n : lo_n);
            OP_REM:   final_res = nr_q ? -hi_n : hi_n;
            default:  final_res = lo_n;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        tgt_d     = tgt_q;
        a_d       = a_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        nq_d      = nq_q;
        nr_d      = nr_q;
        result_d  = result_q;
        tgt_out_d = '0;
        bubble_d  = 1'b1;
        if (kill) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (halt) begin
            tgt_out_d = tgt_out_q;
            bubble_d  = bubble_q;
        end else if (go) begin
            state_d = S_BUSY;
            cnt_d   = CW'(WIDTH - 1);
            op_d    = md_op;
            tgt_d   = tgt;
            hi_d    = '0;
            lo_d    = is_div(md_op) ? mag1 : op2;
            a_d     = is_div(md_op) ? mag2 : op1;
            dz_d    = (op2 == '0);
            nq_d    = sa ^ sb;
            nr_d    = sa;
        end else if (state_q == S_BUSY) begin
            hi_d  = hi_n;
            lo_d  = lo_n;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                result_d  = final_res;
                tgt_out_d = tgt_q;
                bubble_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            tgt_q     <= '0;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
            nq_q      <= 1'b0;
            nr_q      <= 1'b0;
            result_q  <= '0;
            tgt_out_q <= '0;
            bubble_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            tgt_q     <= tgt_d;
            a_q       <= a_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
            nq_q      <= nq_d;
            nr_q      <= nr_d;
            result_q  <= result_d;
            tgt_out_q <= tgt_out_d;
            bubble_q  <= bubble_d;
        end
    end

    assign result     = result_q;
    assign tgt_out    = tgt_out_q;
    assign bubble_out = bubble_q;
    assign busy       = (state_q == S_BUSY);

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed-vector bench for execute_muldiv with hand-computed results.
module tb_execute_muldiv;

    localparam int W  = 32;
    localparam int NF = 4;
    localparam int RB = 5;

    logic          clk = 1'b0;
    logic          rst, halt, kill, bubble_in, md_valid;
    logic [2:0]    md_op;
    logic [RB-1:0] s_1, s_2, tgt;
    logic [W-1:0]  reg_out_1, reg_out_2;
    logic [NF*RB-1:0] fwd_tgt;
    logic [NF*W-1:0]  fwd_data;
    logic [NF-1:0]    fwd_valid;
    logic [W-1:0]  result;
    logic [RB-1:0] tgt_out;
    logic          bubble_out, stall, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_muldiv #(.WIDTH(W), .NFWD(NF), .RBITS(RB)) dut (
        .clk(clk), .rst(rst), .halt(halt), .kill(kill),
        .bubble_in(bubble_in), .md_valid(md_valid), .md_op(md_op),
        .s_1(s_1), .s_2(s_2), .tgt(tgt),
        .reg_out_1(reg_out_1), .reg_out_2(reg_out_2),
        .fwd_tgt(fwd_tgt), .fwd_data(fwd_data), .fwd_valid(fwd_valid),
        .result(result), .tgt_out(tgt_out), .bubble_out(bubble_out),
        .stall(stall), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [2:0] op, input logic [RB-1:0] s1,
                         input logic [31:0] a, input logic [31:0] b);
        md_valid  = 1'b1;
        md_op     = op;
        s_1       = s1;
        s_2       = 5'd2;
        tgt       = 5'd9;
        reg_out_1 = a;
        reg_out_2 = b;
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic [RB-1:0] s1, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input int hold);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        @(posedge clk); #1;
        start(op, s1, a, b);
        for (int k = 0; k < 80 && !done; k++) begin
            @(negedge clk);
            if (stall) n++;
            else done = 1'b1;
            if (!done) begin
                @(posedge clk); #1;
                halt = (hold > 0) && (k + 1 >= 4) && (k + 1 < 4 + hold);
            end
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'(32 + hold));
        @(posedge clk); #1;
        md_valid = 1'b0;
        halt     = 1'b0;
        @(negedge clk);
        check({tag, "_bubble"}, 32'(bubble_out), 32'd0);
        check({tag, "_result"}, result, exp);
        check({tag, "_tgt"}, 32'(tgt_out), 32'd9);
    endtask

    initial begin
        int nres;
        rst = 1'b1; halt = 1'b0; kill = 1'b0; bubble_in = 1'b0;
        md_valid = 1'b0; md_op = '0; s_1 = '0; s_2 = '0; tgt = '0;
        reg_out_1 = '0; reg_out_2 = '0;
        fwd_tgt = '0; fwd_data = '0; fwd_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", result, 32'd0);
        check("rst_bubble", 32'(bubble_out), 32'd1);
        check("rst_tgt", 32'(tgt_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run("mul", 3'd0, 5'd1, 32'd7, 32'd6, 32'd42, 0);
        @(negedge clk);
        check("mul_pulse_end", 32'(bubble_out), 32'd1);
        run("mulhu", 3'd1, 5'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run("mul_ff", 3'd0, 5'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 0);
        run("divu", 3'd2, 5'd1, 32'd100, 32'd7, 32'd14, 0);
        run("remu", 3'd3, 5'd1, 32'd100, 32'd7, 32'd2, 0);
        run("div_neg", 3'd4, 5'd1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0);
        run("rem_neg", 3'd5, 5'd1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0);
        run("divu_z", 3'd2, 5'd1, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
        run("rem_z", 3'd5, 5'd1, 32'd5, 32'd0, 32'd5, 0);
        run("div_negz", 3'd4, 5'd1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 0);
        run("div_min", 3'd4, 5'd1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run("rem_min", 3'd5, 5'd1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 0);
        run("halt", 3'd0, 5'd1, 32'd7, 32'd6, 32'd42, 4);

        @(posedge clk); #1;
        start(3'd0, 5'd1, 32'd7, 32'd6);
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(negedge clk);
        check("kill_stall_c10", 32'(stall), 32'd0);
        @(posedge clk); #1;
        kill     = 1'b0;
        md_valid = 1'b0;
        @(negedge clk);
        check("kill_busy_c11", 32'(busy), 32'd0);
        check("kill_stall_c11", 32'(stall), 32'd0);
        check("kill_bubble_c11", 32'(bubble_out), 32'd1);
        nres = 0;
        repeat (40) begin
            @(negedge clk);
            if (!bubble_out) nres++;
        end
        check("kill_no_result", 32'(nres), 32'd0);

        @(posedge clk); #1;
        start(3'd2, 5'd1, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rstmid_busy_c4", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst      = 1'b1;
        md_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_result", result, 32'd0);
        check("rstmid_bubble", 32'(bubble_out), 32'd1);
        check("rstmid_tgt", 32'(tgt_out), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);

        fwd_tgt   = {5'd7, 5'd1, 5'd7, 5'd1};
        fwd_data  = {32'd0, 32'd9, 32'd0, 32'd3};
        fwd_valid = 4'b0101;
        run("fwd_src0", 3'd0, 5'd1, 32'd77, 32'd1, 32'd3, 0);
        fwd_valid = 4'b0100;
        run("fwd_src2", 3'd0, 5'd1, 32'd77, 32'd1, 32'd9, 0);
        fwd_valid = 4'b0101;
        run("fwd_x0", 3'd0, 5'd0, 32'd77, 32'd1, 32'd0, 0);
        fwd_valid = 4'b0000;
        run("fwd_reg", 3'd0, 5'd1, 32'd77, 32'd1, 32'd77, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
